// File: rtl/room_thermal_model.sv
// Room temperature plant: prescaled heat/cool steps, idle drift to ambient,
// sticky fault when heating and cooling are demanded together.
module room_thermal_model #(
  parameter logic [4:0] TEMP_INIT = 5'd20,
  parameter logic [4:0] AMBIENT   = 5'd12,
  parameter int         HEAT_DIV  = 4,
  parameter int         COOL_DIV  = 2,
  parameter int         DRIFT_DIV = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       heating,
  input  logic       cooling,
  input  logic       load,
  input  logic [4:0] load_val,
  output logic [4:0] temperature,
  output logic       fault
);

  localparam int MAXHC  = (HEAT_DIV > COOL_DIV) ? HEAT_DIV : COOL_DIV;
  localparam int MAXDIV = (MAXHC > DRIFT_DIV) ? MAXHC : DRIFT_DIV;
  localparam int CW     = (MAXDIV > 1) ? $clog2(MAXDIV) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    COOL = 2'b01,
    HEAT = 2'b10,
    BOTH = 2'b11
  } mode_t;

  mode_t         mode;
  mode_t         smode;
  logic [CW-1:0] cnt;
  logic [CW-1:0] lim;
  logic [4:0]    stepped;

  assign smode = mode_t'({heating, cooling});

  always_comb begin
    lim = '0;
    unique case (mode)
      IDLE: lim = CW'(DRIFT_DIV - 1);
      COOL: lim = CW'(COOL_DIV - 1);
      HEAT: lim = CW'(HEAT_DIV - 1);
      BOTH: lim = '0;
    endcase
  end

  // Saturating step; idle moves one count toward ambient
  always_comb begin
    stepped = temperature;
    unique case (mode)
      HEAT: if (temperature != 5'd31) stepped = temperature + 5'd1;
      COOL: if (temperature != 5'd0) stepped = temperature - 5'd1;
      IDLE: begin
        if (temperature > AMBIENT)
          stepped = temperature - 5'd1;
        else if (temperature < AMBIENT)
          stepped = temperature + 5'd1;
      end
      BOTH: stepped = temperature;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      temperature <= TEMP_INIT;
      fault       <= 1'b0;
      mode        <= IDLE;
      cnt         <= '0;
    end else begin
      if (!load && smode == BOTH)
        fault <= 1'b1;
      if (load) begin
        temperature <= load_val;
        cnt         <= '0;
        mode        <= smode;
      end else if (smode != mode) begin
        mode <= smode;
        cnt  <= '0;
      end else if (mode == BOTH) begin
        cnt <= '0;
      end else if (cnt == lim) begin
        temperature <= stepped;
        cnt         <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_room_thermal_model.sv
// Directed bench for room_thermal_model.
// Checks prescaled steps, saturation, fault, reset.
module tb_room_thermal_model;

  logic       clk = 1'b0;
  logic       rst;
  logic       heating;
  logic       cooling;
  logic       load;
  logic [4:0] load_val;
  logic [4:0] temperature;
  logic       fault;

  int n_tests = 0;
  int n_fail  = 0;

  room_thermal_model dut (
    .clk(clk), .rst(rst), .heating(heating), .cooling(cooling),
    .load(load), .load_val(load_val),
    .temperature(temperature), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic expect_st(input string nm, input logic [4:0] t,
                           input logic f);
    n_tests++;
    if (temperature !== t || fault !== f) begin
      n_fail++;
      $display("FAIL %s: got temp=%0d fault=%b, want temp=%0d fault=%b",
               nm, temperature, fault, t, f);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    heating = 1'b0;
    cooling = 1'b0;
    load = 1'b0;
    load_val = 5'd0;
    step(2);
    expect_st("reset", 5'd20, 1'b0);
    rst = 1'b0;

    step(7);
    expect_st("idle7", 5'd20, 1'b0);
    step(1);
    expect_st("idle8", 5'd19, 1'b0);
    step(8);
    expect_st("idle16", 5'd18, 1'b0);

    heating = 1'b1;
    step(1);
    expect_st("heat_entry", 5'd18, 1'b0);
    step(3);
    expect_st("heat_e4", 5'd18, 1'b0);
    step(1);
    expect_st("heat_e5", 5'd19, 1'b0);
    step(4);
    expect_st("heat_e9", 5'd20, 1'b0);
    load = 1'b1;
    load_val = 5'd30;
    step(1);
    expect_st("load30", 5'd30, 1'b0);
    load = 1'b0;
    step(4);
    expect_st("heat31", 5'd31, 1'b0);
    step(12);
    n_tests++;
    if (temperature !== 5'd31 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL heat_sat: temp=%0d fault=%b", temperature, fault);
    end

    heating = 1'b0;
    load = 1'b1;
    load_val = 5'd1;
    step(1);
    expect_st("load1", 5'd1, 1'b0);
    load = 1'b0;
    cooling = 1'b1;
    step(2);
    expect_st("cool_e2", 5'd1, 1'b0);
    step(1);
    expect_st("cool_e3", 5'd0, 1'b0);
    step(6);
    n_tests++;
    if (temperature !== 5'd0 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL cool_sat: temp=%0d fault=%b", temperature, fault);
    end

    cooling = 1'b0;
    load = 1'b1;
    load_val = 5'd15;
    step(1);
    expect_st("load15", 5'd15, 1'b0);
    load = 1'b0;
    heating = 1'b1;
    cooling = 1'b1;
    step(1);
    expect_st("both_e1", 5'd15, 1'b1);
    step(2);
    expect_st("both_e3", 5'd15, 1'b1);
    heating = 1'b0;
    cooling = 1'b0;
    step(8);
    expect_st("rel_e8", 5'd15, 1'b1);
    step(1);
    n_tests++;
    if (temperature !== 5'd14 || fault !== 1'b1) begin
      n_fail++;
      $display("FAIL rel_e9: temp=%0d fault=%b", temperature, fault);
    end

    heating = 1'b1;
    load = 1'b1;
    load_val = 5'd25;
    step(1);
    load = 1'b0;
    step(2);
    expect_st("heat_cnt2", 5'd25, 1'b1);
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (temperature !== 5'd20 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst: temp=%0d fault=%b", temperature, fault);
    end
    #1 rst = 1'b0;
    heating = 1'b0;
    step(7);
    expect_st("post_rst7", 5'd20, 1'b0);
    step(1);
    n_tests++;
    if (temperature !== 5'd19 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL post_rst8: temp=%0d fault=%b", temperature, fault);
    end

    load = 1'b1;
    load_val = 5'd12;
    step(1);
    load = 1'b0;
    step(20);
    expect_st("ambient_hold", 5'd12, 1'b0);
    load = 1'b1;
    load_val = 5'd5;
    step(1);
    load = 1'b0;
    step(7);
    expect_st("drift_up7", 5'd5, 1'b0);
    step(1);
    expect_st("drift_up8", 5'd6, 1'b0);
    for (int i = 0; i < 5; i++) begin
      heating = 1'b1;
      step(2);
      heating = 1'b0;
      step(2);
      n_tests++;
      if (temperature !== 5'd6 || fault !== 1'b0) begin
        n_fail++;
        $display("FAIL toggle %0d: temp=%0d fault=%b",
                 i, temperature, fault);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
